// File: rtl/xillybus_seekable_regbank_if.sv
// Bundle of the host seekable-stream and fabric-side signals of the register bank.
//
// Handshake semantics: every host strobe is a valid/ready pair sampled on the
// rising edge of bus_clk. A host write transfers when user_w_wren is high,
// user_w_open is high and user_w_full is low in the same cycle. A host read
// transfers when user_r_rden is high, user_r_open is high and user_r_empty is
// low, and its word appears on user_r_data in the following cycle. The fabric
// ports have no back-pressure: fab_we is a plain strobe whose loss to a
// concurrent host write is reported by fab_collision in the next cycle.
interface xillybus_seekable_regbank_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] user_addr;
  logic              user_addr_update;
  logic              user_w_wren;
  logic [DATA_W-1:0] user_w_data;
  logic              user_w_full;
  logic              user_w_open;
  logic              user_r_rden;
  logic [DATA_W-1:0] user_r_data;
  logic              user_r_empty;
  logic              user_r_eof;
  logic              user_r_open;
  logic [ADDR_W-1:0] fab_rd_addr;
  logic [DATA_W-1:0] fab_rd_data;
  logic              fab_we;
  logic [ADDR_W-1:0] fab_waddr;
  logic [DATA_W-1:0] fab_wdata;
  logic              fab_collision;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic [DATA_W-1:0] upd_data;
  // Debug visibility of the prefetch state machine and the seek pointer.
  logic [1:0]        dbg_state;
  logic [ADDR_W:0]   dbg_ptr;

  modport master (
    output user_addr, user_addr_update, user_w_wren, user_w_data, user_w_open,
           user_r_rden, user_r_open, fab_rd_addr, fab_we, fab_waddr, fab_wdata,
    input  user_w_full, user_r_data, user_r_empty, user_r_eof, fab_rd_data,
           fab_collision, upd_valid, upd_addr, upd_data, dbg_state, dbg_ptr
  );

  modport slave (
    input  user_addr, user_addr_update, user_w_wren, user_w_data, user_w_open,
           user_r_rden, user_r_open, fab_rd_addr, fab_we, fab_waddr, fab_wdata,
    output user_w_full, user_r_data, user_r_empty, user_r_eof, fab_rd_data,
           fab_collision, upd_valid, upd_addr, upd_data, dbg_state, dbg_ptr
  );
endinterface

// File: rtl/xillybus_seekable_regbank.sv
// Seekable register bank: one DEPTH x DATA_W synchronous RAM shared by a host
// write stream, a host read stream (common auto-incrementing seek pointer)
// and an independent fabric read/write port.
module xillybus_seekable_regbank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter bit WRAP   = 1'b0
) (
  input logic bus_clk,
  input logic reset,
  xillybus_seekable_regbank_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] PTR_END = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] ONE_P = {{ADDR_W{1'b0}}, 1'b1};

  // INVALID: staged word stale; FETCH: RAM read in flight; READY: stage holds mem[ptr]
  typedef enum logic [1:0] {
    ST_INVALID = 2'd0,
    ST_FETCH   = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] stage_q, stage_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              r_empty_q, r_empty_d;
  logic              upd_valid_q, upd_valid_d;
  logic [ADDR_W-1:0] upd_addr_q, upd_addr_d;
  logic [DATA_W-1:0] upd_data_q, upd_data_d;
  logic [DATA_W-1:0] fab_rd_data_q, fab_rd_data_d;
  logic              fab_collision_q, fab_collision_d;

  logic              at_end;
  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W:0]   ptr_nxt;
  logic [ADDR_W-1:0] hit_addr;
  logic              fab_hit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Pointer advance: modulo DEPTH when wrapping, otherwise parks at DEPTH.
  function automatic logic [ADDR_W:0] ptr_next(input logic [ADDR_W:0] p);
    if (WRAP) begin
      return {1'b0, p[ADDR_W-1:0] + ONE_A};
    end else if (p == PTR_END) begin
      return p;
    end else begin
      return p + ONE_P;
    end
  endfunction

  // Next-state, RAM port steering and output computation.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    stage_d         = stage_q;
    r_data_d        = r_data_q;
    upd_valid_d     = 1'b0;
    upd_addr_d      = upd_addr_q;
    upd_data_d      = upd_data_q;
    fab_collision_d = 1'b0;
    fab_rd_data_d   = mem[bus.fab_rd_addr];
    mem_we          = 1'b0;
    mem_waddr       = bus.fab_waddr;
    mem_wdata       = bus.fab_wdata;
    fab_hit         = 1'b0;

    at_end  = !WRAP && (ptr_q == PTR_END);
    ptr_nxt = ptr_next(ptr_q);
    wr_acc  = !bus.user_addr_update && bus.user_w_wren && bus.user_w_open && !at_end;
    rd_acc  = !bus.user_addr_update && !wr_acc && bus.user_r_rden && bus.user_r_open
              && !r_empty_q;
    // The word the prefetch depends on: the next one when a read advances the
    // pointer this cycle, otherwise the one at the pointer.
    hit_addr = rd_acc ? ptr_nxt[ADDR_W-1:0] : ptr_q[ADDR_W-1:0];

    // A host write owns the RAM write port; a concurrent fabric write is lost.
    if (wr_acc) begin
      mem_we          = 1'b1;
      mem_waddr       = ptr_q[ADDR_W-1:0];
      mem_wdata       = bus.user_w_data;
      fab_collision_d = bus.fab_we;
    end else if (bus.fab_we) begin
      mem_we  = 1'b1;
      fab_hit = (bus.fab_waddr == hit_addr);
    end

    if (bus.user_addr_update) begin
      ptr_d   = {1'b0, bus.user_addr};
      state_d = ST_INVALID;
    end else if (wr_acc) begin
      ptr_d       = ptr_nxt;
      state_d     = ST_INVALID;
      upd_valid_d = 1'b1;
      upd_addr_d  = ptr_q[ADDR_W-1:0];
      upd_data_d  = bus.user_w_data;
    end else if (rd_acc) begin
      r_data_d = stage_q;
      ptr_d    = ptr_nxt;
      if (ptr_nxt == PTR_END || fab_hit) begin
        state_d = ST_INVALID;
      end else begin
        stage_d = mem[ptr_nxt[ADDR_W-1:0]];
        state_d = ST_READY;
      end
    end else begin
      case (state_q)
        // Skip the fetch if the fabric is rewriting that word right now,
        // otherwise the read-before-write RAM would stage the old value.
        ST_INVALID: begin
          if (ptr_q != PTR_END && !fab_hit) begin
            stage_d = mem[ptr_q[ADDR_W-1:0]];
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: state_d = fab_hit ? ST_INVALID : ST_READY;
        ST_READY: begin
          if (fab_hit) state_d = ST_INVALID;
        end
        default: state_d = ST_INVALID;
      endcase
    end

    r_empty_d = (state_d != ST_READY);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge bus_clk) begin
    if (reset) begin
      state_q         <= ST_INVALID;
      ptr_q           <= '0;
      stage_q         <= '0;
      r_data_q        <= '0;
      r_empty_q       <= 1'b1;
      upd_valid_q     <= 1'b0;
      upd_addr_q      <= '0;
      upd_data_q      <= '0;
      fab_rd_data_q   <= '0;
      fab_collision_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      stage_q         <= stage_d;
      r_data_q        <= r_data_d;
      r_empty_q       <= r_empty_d;
      upd_valid_q     <= upd_valid_d;
      upd_addr_q      <= upd_addr_d;
      upd_data_q      <= upd_data_d;
      fab_rd_data_q   <= fab_rd_data_d;
      fab_collision_q <= fab_collision_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge bus_clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.user_r_data   = r_data_q;
  assign bus.user_r_empty  = r_empty_q;
  assign bus.user_r_eof    = !WRAP && (ptr_q == PTR_END);
  assign bus.user_w_full   = !WRAP && (ptr_q == PTR_END);
  assign bus.fab_rd_data   = fab_rd_data_q;
  assign bus.fab_collision = fab_collision_q;
  assign bus.upd_valid     = upd_valid_q;
  assign bus.upd_addr      = upd_addr_q;
  assign bus.upd_data      = upd_data_q;
  assign bus.dbg_state     = state_q;
  assign bus.dbg_ptr       = ptr_q;
endmodule

// File: tb/tb_xillybus_seekable_regbank.sv
// Bench for xillybus_seekable_regbank: a WRAP=0 and a WRAP=1 instance share one
// stimulus stream; a behavioural model per instance is compared every cycle.
module tb_xillybus_seekable_regbank;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  // ---------------- clock / reset ----------------
  logic bus_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 bus_clk = ~bus_clk;

  xillybus_seekable_regbank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
  xillybus_seekable_regbank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

  xillybus_seekable_regbank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRAP(1'b0)) dut0 (
    .bus_clk(bus_clk), .reset(reset), .bus(bus0.slave)
  );
  xillybus_seekable_regbank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WRAP(1'b1)) dut1 (
    .bus_clk(bus_clk), .reset(reset), .bus(bus1.slave)
  );

  // The WRAP=1 instance sees exactly the same inputs.
  assign bus1.user_addr        = bus0.user_addr;
  assign bus1.user_addr_update = bus0.user_addr_update;
  assign bus1.user_w_wren      = bus0.user_w_wren;
  assign bus1.user_w_data      = bus0.user_w_data;
  assign bus1.user_w_open      = bus0.user_w_open;
  assign bus1.user_r_rden      = bus0.user_r_rden;
  assign bus1.user_r_open      = bus0.user_r_open;
  assign bus1.fab_rd_addr      = bus0.fab_rd_addr;
  assign bus1.fab_we           = bus0.fab_we;
  assign bus1.fab_waddr        = bus0.fab_waddr;
  assign bus1.fab_wdata        = bus0.fab_wdata;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];

  bit                model_valid = 1'b0;
  bit                m_wrap [2] = '{1'b0, 1'b1};
  logic [DATA_W-1:0] m_mem [2][DEPTH];
  bit                m_known [2][DEPTH];
  int                m_ptr [2];
  int                m_since [2];   // cycles since the staged word went stale
  logic [DATA_W-1:0] m_rdata [2];
  logic [DATA_W-1:0] m_fab_rd [2];
  bit                m_fab_known [2];
  bit                m_coll [2];
  bit                m_upd_valid [2];
  logic [ADDR_W-1:0] m_upd_addr [2];
  logic [DATA_W-1:0] m_upd_data [2];
  bit                m_rd_fired [2];

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Behavioural model: one bus_clk edge for instance k.
  task automatic model_step(input int k);
    bit endp, ready, wr_acc, rd_acc, upd;
    int nxt, hit, cur;
    m_rd_fired[k] = 1'b0;
    if (reset) begin
      m_ptr[k] = 0; m_since[k] = 0; m_rdata[k] = '0;
      m_fab_rd[k] = '0; m_fab_known[k] = 1'b1; m_coll[k] = 1'b0;
      m_upd_valid[k] = 1'b0; m_upd_addr[k] = '0; m_upd_data[k] = '0;
      return;
    end
    if (!model_valid) return;
    cur    = m_ptr[k] % DEPTH;
    endp   = !m_wrap[k] && (m_ptr[k] == DEPTH);
    ready  = (m_ptr[k] < DEPTH) && (m_since[k] >= 2);
    nxt    = m_wrap[k] ? (m_ptr[k] + 1) % DEPTH
                       : ((m_ptr[k] == DEPTH) ? DEPTH : m_ptr[k] + 1);
    upd    = bus0.user_addr_update;
    wr_acc = !upd && bus0.user_w_wren && bus0.user_w_open && !endp;
    rd_acc = !upd && !wr_acc && bus0.user_r_rden && bus0.user_r_open && ready;

    m_fab_rd[k]    = m_mem[k][bus0.fab_rd_addr];
    m_fab_known[k] = m_known[k][bus0.fab_rd_addr];
    m_coll[k]      = wr_acc && bus0.fab_we;
    m_upd_valid[k] = wr_acc;
    if (wr_acc) begin
      m_upd_addr[k] = ADDR_W'(cur);
      m_upd_data[k] = bus0.user_w_data;
    end
    if (rd_acc) begin
      m_rdata[k] = m_mem[k][cur];
      m_rd_fired[k] = 1'b1;
      if (k == 0) exp_q0.push_back(m_mem[k][cur]);
      else        exp_q1.push_back(m_mem[k][cur]);
    end

    hit = rd_acc ? (nxt % DEPTH) : cur;
    if (upd || wr_acc) m_since[k] = 0;
    else if (bus0.fab_we && (int'(bus0.fab_waddr) == hit)) m_since[k] = 0;
    else if (rd_acc && nxt == DEPTH) m_since[k] = 0;
    else if (m_since[k] < 2) m_since[k]++;

    if (wr_acc) begin
      m_mem[k][cur] = bus0.user_w_data; m_known[k][cur] = 1'b1;
    end else if (bus0.fab_we) begin
      m_mem[k][bus0.fab_waddr] = bus0.fab_wdata; m_known[k][bus0.fab_waddr] = 1'b1;
    end

    if (upd) m_ptr[k] = int'(bus0.user_addr);
    else if (wr_acc || rd_acc) m_ptr[k] = nxt;
  endtask

  always @(posedge bus_clk) begin
    model_step(0);
    model_step(1);
    if (reset) model_valid = 1'b1;
  end

  task automatic cmp_inst(input int k, input logic [DATA_W-1:0] r_data, input logic r_empty,
                          input logic eof, input logic full, input logic [DATA_W-1:0] fab_rd,
                          input logic coll, input logic upd_v, input logic [ADDR_W-1:0] upd_a,
                          input logic [DATA_W-1:0] upd_d, input logic [ADDR_W:0] ptr);
    logic [DATA_W-1:0] e;
    bit endp;
    endp = !m_wrap[k] && (m_ptr[k] == DEPTH);
    check("r_data", k, r_data, m_rdata[k]);
    if (m_rd_fired[k]) begin
      if (k == 0) e = (exp_q0.size() > 0) ? exp_q0.pop_front() : '0;
      else        e = (exp_q1.size() > 0) ? exp_q1.pop_front() : '0;
      check("rd_word", k, r_data, e);
    end
    check("r_empty", k, r_empty, !((m_ptr[k] < DEPTH) && (m_since[k] >= 2)));
    check("r_eof", k, eof, endp);
    check("w_full", k, full, endp);
    if (m_fab_known[k]) check("fab_rd_data", k, fab_rd, m_fab_rd[k]);
    check("fab_collision", k, coll, m_coll[k]);
    check("upd_valid", k, upd_v, m_upd_valid[k]);
    check("upd_addr", k, upd_a, m_upd_addr[k]);
    check("upd_data", k, upd_d, m_upd_data[k]);
    check("ptr", k, ptr, m_ptr[k]);
  endtask

  // Compare process: both instances against the model on every falling edge.
  always @(negedge bus_clk) begin
    if (model_valid) begin
      cmp_inst(0, bus0.user_r_data, bus0.user_r_empty, bus0.user_r_eof, bus0.user_w_full,
               bus0.fab_rd_data, bus0.fab_collision, bus0.upd_valid, bus0.upd_addr,
               bus0.upd_data, bus0.dbg_ptr);
      cmp_inst(1, bus1.user_r_data, bus1.user_r_empty, bus1.user_r_eof, bus1.user_w_full,
               bus1.fab_rd_data, bus1.fab_collision, bus1.upd_valid, bus1.upd_addr,
               bus1.upd_data, bus1.dbg_ptr);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic seek(input int a);
    bus0.user_addr = ADDR_W'(a);
    bus0.user_addr_update = 1'b1;
    cyc();
    bus0.user_addr_update = 1'b0;
  endtask

  // Time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    bus0.user_addr = '0; bus0.user_addr_update = 1'b0;
    bus0.user_w_wren = 1'b0; bus0.user_w_data = '0; bus0.user_w_open = 1'b1;
    bus0.user_r_rden = 1'b0; bus0.user_r_open = 1'b1;
    bus0.fab_rd_addr = '0; bus0.fab_we = 1'b0; bus0.fab_waddr = '0; bus0.fab_wdata = '0;
    reset = 1'b1;
    repeat (3) cyc();
    check("rst_r_empty", 0, bus0.user_r_empty, 1);
    check("rst_r_data", 0, bus0.user_r_data, 0);
    check("rst_w_full", 0, bus0.user_w_full, 0);
    check("rst_r_eof", 0, bus0.user_r_eof, 0);
    check("rst_upd_valid", 0, bus0.upd_valid, 0);
    check("rst_fab_rd", 0, bus0.fab_rd_data, 0);
    check("rst_collision", 1, bus1.fab_collision, 0);
    reset = 1'b0;

    // Preload every word from the fabric side.
    for (int i = 0; i < DEPTH; i++) begin
      bus0.fab_we = 1'b1; bus0.fab_waddr = ADDR_W'(i); bus0.fab_wdata = DATA_W'(16'hA000 + i);
      cyc();
    end
    bus0.fab_we = 1'b0;

    // Host writes 0x1111..0x1114 from address 0.
    seek(0);
    for (int i = 0; i < 4; i++) begin
      bus0.user_w_wren = 1'b1; bus0.user_w_data = DATA_W'(16'h1111 + i);
      cyc();
      check("wr_upd_valid", 0, bus0.upd_valid, 1);
      check("wr_upd_addr", 0, bus0.upd_addr, i);
      check("wr_upd_data", 0, bus0.upd_data, 16'h1111 + i);
    end
    bus0.user_w_wren = 1'b0;
    cyc();
    check("wr_upd_pulse_end", 0, bus0.upd_valid, 0);
    bus0.fab_rd_addr = 5'd2;
    cyc();
    check("fab_rd_2", 0, bus0.fab_rd_data, 16'h1113);

    // Seek 1 and stream reads.
    seek(1);
    check("seek_empty0", 0, bus0.user_r_empty, 1);
    cyc();
    check("seek_empty1", 0, bus0.user_r_empty, 1);
    cyc();
    check("seek_ready", 0, bus0.user_r_empty, 0);
    bus0.user_r_rden = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stream_rd", 0, bus0.user_r_data, 16'h1112 + i);
    end
    bus0.user_r_rden = 1'b0;
    cyc();
    check("rd_hold", 0, bus0.user_r_data, 16'h1114);

    // End-of-bank on the WRAP=0 instance.
    seek(30);
    for (int i = 0; i < 3; i++) begin
      bus0.user_w_wren = 1'b1; bus0.user_w_data = DATA_W'(16'h2001 + i);
      cyc();
      if (i == 1) begin
        check("end_full", 0, bus0.user_w_full, 1);
        check("end_upd_addr", 0, bus0.upd_addr, 31);
      end
    end
    bus0.user_w_wren = 1'b0;
    check("end_blocked", 0, bus0.upd_valid, 0);
    check("end_eof", 0, bus0.user_r_eof, 1);
    check("end_empty", 0, bus0.user_r_empty, 1);
    check("end_ptr", 0, bus0.dbg_ptr, 32);
    check("wrap_upd_addr", 1, bus1.upd_addr, 0);

    // Wrapping read on the WRAP=1 instance.
    seek(31);
    cyc(); cyc();
    check("wrap_ready", 1, bus1.user_r_empty, 0);
    bus0.user_r_rden = 1'b1;
    cyc();
    check("wrap_rd31", 1, bus1.user_r_data, 16'h2002);
    check("wrap_empty_a", 1, bus1.user_r_empty, 0);
    cyc();
    check("wrap_rd0", 1, bus1.user_r_data, 16'h2003);
    check("wrap_empty_b", 1, bus1.user_r_empty, 0);
    bus0.user_r_rden = 1'b0;
    cyc();
    check("wrap_ptr", 1, bus1.dbg_ptr, 1);
    check("nowrap_eof", 0, bus0.user_r_eof, 1);

    // Host/fabric write collision at address 5.
    seek(5);
    bus0.user_w_wren = 1'b1; bus0.user_w_data = 16'h3333;
    bus0.fab_we = 1'b1; bus0.fab_waddr = 5'd5; bus0.fab_wdata = 16'h4444;
    cyc();
    check("coll_pulse", 0, bus0.fab_collision, 1);
    bus0.user_w_wren = 1'b0; bus0.fab_we = 1'b0;
    bus0.fab_rd_addr = 5'd5;
    cyc();
    check("coll_end", 0, bus0.fab_collision, 0);
    cyc();
    check("coll_host_wins", 0, bus0.fab_rd_data, 16'h3333);

    // Fabric write under the pointer invalidates the prefetch.
    seek(5);
    cyc(); cyc();
    check("fab_pre_ready", 0, bus0.user_r_empty, 0);
    bus0.fab_we = 1'b1; bus0.fab_waddr = 5'd5; bus0.fab_wdata = 16'h5555;
    cyc();
    bus0.fab_we = 1'b0;
    check("fab_inv0", 0, bus0.user_r_empty, 1);
    cyc();
    check("fab_inv1", 0, bus0.user_r_empty, 1);
    cyc();
    check("fab_reready", 0, bus0.user_r_empty, 0);
    bus0.user_r_rden = 1'b1;
    cyc();
    bus0.user_r_rden = 1'b0;
    check("fab_rd_val", 0, bus0.user_r_data, 16'h5555);
    check("fab_rd_val", 1, bus1.user_r_data, 16'h5555);

    // Reset in the middle of a read burst.
    seek(0);
    cyc(); cyc();
    bus0.user_r_rden = 1'b1;
    cyc(); cyc();
    check("burst_rd1", 0, bus0.user_r_data, 16'h1112);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus0.user_r_rden = 1'b0;
    check("mid_rst_empty", 0, bus0.user_r_empty, 1);
    check("mid_rst_data", 0, bus0.user_r_data, 0);
    check("mid_rst_ptr", 0, bus0.dbg_ptr, 0);
    cyc(); cyc();
    check("post_rst_ready", 0, bus0.user_r_empty, 0);
    bus0.user_r_rden = 1'b1;
    cyc();
    check("post_rst_rd0", 0, bus0.user_r_data, 16'h1111);
    check("post_rst_rd0", 1, bus1.user_r_data, 16'h2003);
    cyc();
    check("post_rst_rd1", 0, bus0.user_r_data, 16'h1112);
    bus0.user_r_rden = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
